cpu_mmu_csr_ctl: RTL and testbench
==================================

Name: cpu_mmu_csr_ctl

Overview:
Write side and control engine of the cache status register (CSR). Captures CUP/CON from the internal data bus IDB on a CSR load strobe and runs a cache-invalidate sequencer. The sequencer walks every cache tag address and writes invalid entries. It drives the CUP/CON levels that the CSR read buffer later returns on IDB.

Parameters:
ADDR_W, 10, cache tag address width; the sequencer clears 2**ADDR_W entries.

Ports:
sysclk  input  1  system clock; all state changes on its rising edge.
sys_rst  input  1  synchronous reset, active-high.
IDB_3_0  input  4  internal data bus low nibble. Bit0 = CUP, bit1 = CON, bit2 = start invalidate (self-clearing), bit3 = reserved, ignored.
LCSR_n  input  1  CSR load strobe, active low, sampled each cycle.
CUP  output  1  cache-upper select, registered.
CON  output  1  cache-on as written by software, registered.
CON_EFF  output  1  effective cache enable = CON & ~BUSY.
BUSY  output  1  high while the invalidate sequence runs.
CADR  output  ADDR_W  tag address during invalidate; 0 when idle.
CWE_n  output  1  tag RAM write enable, active low, asserted once per address during invalidate.
CDONE  output  1  one-cycle pulse on the cycle after the last entry is written.

Behaviour:
- Reset: sys_rst high at an edge forces CUP=0, CON=0, BUSY=0, CADR=0, CWE_n=1, CDONE=0, state IDLE. This holds even if a sequence is in progress, which is abandoned without completion. Reset has priority over LCSR_n.
- CSR load: LCSR_n low at an edge loads CUP<=IDB_3_0[0] and CON<=IDB_3_0[1]. New values are visible the next cycle. The load is accepted in every state.
- Consecutive low cycles of LCSR_n each load; the last one wins.
- State machine: IDLE, CLEAR, DONE.
- IDLE -> CLEAR: on an edge where LCSR_n=0 and IDB_3_0[1:0]... specifically IDB_3_0[2]=1. On the next cycle BUSY=1, CADR=0, CWE_n=0.
- CLEAR: each cycle CWE_n=0 with the current CADR. CADR increments by 1 per cycle (ADDR_W-bit, no wrap past the end). When CADR = 2**ADDR_W-1, the next state is DONE.
- CLEAR lasts exactly 2**ADDR_W cycles.
- DONE: BUSY=0, CWE_n=1, CADR=0, CDONE=1 for one cycle. Then IDLE.
- A start request (bit2=1) received in CLEAR or DONE is ignored. The CUP/CON fields of that same write are still loaded.
- A start request in IDLE combined with a CON=1 write: CON reads 1, but CON_EFF stays 0 until BUSY drops. The cache is never enabled on partially cleared tags.
- CON_EFF is combinational from registered CON and BUSY. No other output is combinational.
- IDB_3_0[3] has no effect in any state.
- Latency:
  - LCSR_n to CUP/CON: 1 cycle.
  - Start to first CWE_n: 1 cycle.
  - Start to CDONE: 2**ADDR_W + 1 cycles.

Decomposition:
- Shared package (cpu_mmu_pkg): state encoding constants (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2) and the IDB bit-index constants (CSR_CUP_BIT=0, CSR_CON_BIT=1, CSR_INV_BIT=2).
- One natural sub-module: cpu_mmu_csr_clrseq. It holds the state machine and the CADR counter. Inputs are the start pulse and clock/reset; outputs are BUSY, CADR, CWE_n and CDONE.
- The top level holds the CUP/CON registers and CON_EFF.

Test Plan:
- Reset with ADDR_W=4: assert sys_rst 2 cycles -> CUP=0, CON=0, BUSY=0, CADR=0, CWE_n=1, CDONE=0.
- Plain load: LCSR_n=0 one cycle with IDB=4'b0011 -> next cycle CUP=1, CON=1, CON_EFF=1, BUSY stays 0, CWE_n stays 1.
- Full invalidate, ADDR_W=4:
  - Stimulus: LCSR_n=0 with IDB=4'b0110.
  - CON=1 and CON_EFF=0 for the whole sequence.
  - CWE_n=0 for 16 cycles with CADR = 0..15 in order.
  - Then CDONE=1 for one cycle, BUSY=0 and CON_EFF=1 after the sequence.
- Write during CLEAR: at CADR=5, LCSR_n=0 with IDB=4'b0101 -> CUP=1 and CON=0 next cycle. The sequence is not restarted; CADR continues 6..15 and CDONE still arrives at the same cycle.
- Reset mid-sequence: at CADR=9, pulse sys_rst one cycle -> next cycle BUSY=0, CADR=0, CWE_n=1, CUP=CON=0, and no CDONE pulse follows.
- Reserved bit: LCSR_n=0 with IDB=4'b1000 -> CUP=0, CON=0, no sequence started, all outputs unchanged from reset values.

Source files
------------

// File: rtl/cpu_mmu_pkg.sv
// Shared definitions for the MMU cache status register (CSR) logic.
//   - clr_state_e : encoding of the cache-invalidate sequencer states
//   - CSR_*_BIT   : bit positions of the CSR fields on the IDB low nibble
package cpu_mmu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    localparam int CSR_CUP_BIT = 0;
    localparam int CSR_CON_BIT = 1;
    localparam int CSR_INV_BIT = 2;

endpackage

// File: rtl/cpu_mmu_csr_clrseq.sv
// Cache-invalidate sequencer. Walks every tag address once, writing an
// invalid entry per cycle, then emits a one-cycle completion pulse.
// Ports:
//   sysclk    in   system clock, rising edge
//   sys_rst   in   synchronous active-high reset, abandons any sequence
//   start     in   one-cycle start request; only honoured in IDLE
//   busy      out  high for the whole CLEAR phase
//   cadr      out  tag address being written; 0 outside CLEAR
//   cwe_n     out  tag RAM write enable, active low, one per address
//   cdone     out  one-cycle pulse on the cycle after the last write
//   state_dbg out  current sequencer state, for probing
//
// Handshake: start is a fire-and-forget pulse with no ready back. A start
// seen while a sequence is running (CLEAR or DONE) is dropped, not queued.
module cpu_mmu_csr_clrseq
    import cpu_mmu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              sysclk,
    input  logic              sys_rst,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] cadr,
    output logic              cwe_n,
    output logic              cdone,
    output clr_state_e        state_dbg
);

    localparam logic [ADDR_W-1:0] CADR_ONE  = 1;
    localparam logic [ADDR_W-1:0] CADR_LAST = '1;

    clr_state_e state;

    assign state_dbg = state;

    // All outputs are registered and updated alongside the state so that
    // busy/cadr/cwe_n change together with no combinational decode.
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            cadr  <= '0;
            cwe_n <= 1'b1;
            cdone <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cdone <= 1'b0;
                    if (start) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        cadr  <= '0;
                        cwe_n <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (cadr == CADR_LAST) begin
                        // Last entry was written this cycle: leave without
                        // letting the counter wrap back to zero in CLEAR.
                        state <= DONE;
                        busy  <= 1'b0;
                        cadr  <= '0;
                        cwe_n <= 1'b1;
                        cdone <= 1'b1;
                    end else begin
                        cadr  <= cadr + CADR_ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cdone <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cadr  <= '0;
                    cwe_n <= 1'b1;
                    cdone <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cpu_mmu_csr_ctl.sv
// Write side and control engine of the cache status register. Loads CUP and
// CON from the IDB low nibble on the CSR load strobe and launches the tag
// invalidate sequencer when the start bit is written.
// Ports:
//   sysclk   in   system clock, rising edge
//   sys_rst  in   synchronous active-high reset
//   IDB_3_0  in   [0]=CUP [1]=CON [2]=start invalidate [3]=reserved
//   LCSR_n   in   CSR load strobe, active low, sampled every cycle
//   CUP      out  cache-upper select, registered
//   CON      out  cache-on as written by software, registered
//   CON_EFF  out  CON gated off while the invalidate sequence runs
//   BUSY     out  invalidate sequence in progress
//   CADR     out  tag address during invalidate, 0 when idle
//   CWE_n    out  tag RAM write enable, active low
//   CDONE    out  one-cycle pulse after the last tag is written
module cpu_mmu_csr_ctl
    import cpu_mmu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              sysclk,
    input  logic              sys_rst,
    input  logic [3:0]        IDB_3_0,
    input  logic              LCSR_n,
    output logic              CUP,
    output logic              CON,
    output logic              CON_EFF,
    output logic              BUSY,
    output logic [ADDR_W-1:0] CADR,
    output logic              CWE_n,
    output logic              CDONE
);

    logic       inv_start;
    clr_state_e seq_state;
    logic [2:0] unused_sink;

    // The start bit self-clears: it is a request, not a stored CSR field.
    assign inv_start = ~LCSR_n & IDB_3_0[CSR_INV_BIT];

    // Reserved IDB bit and the probe-only sequencer state have no function.
    assign unused_sink = {IDB_3_0[3], seq_state};

    // CSR fields load in every sequencer state; repeated strobes simply
    // overwrite, so the last write wins.
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            CUP <= 1'b0;
            CON <= 1'b0;
        end else if (!LCSR_n) begin
            CUP <= IDB_3_0[CSR_CUP_BIT];
            CON <= IDB_3_0[CSR_CON_BIT];
        end
    end

    // Never expose the cache as enabled while tags are only partly cleared.
    assign CON_EFF = CON & ~BUSY;

    cpu_mmu_csr_clrseq #(
        .ADDR_W (ADDR_W)
    ) u_clrseq (
        .sysclk    (sysclk),
        .sys_rst   (sys_rst),
        .start     (inv_start),
        .busy      (BUSY),
        .cadr      (CADR),
        .cwe_n     (CWE_n),
        .cdone     (CDONE),
        .state_dbg (seq_state)
    );

endmodule

// File: tb/tb_cpu_mmu_csr_ctl.sv
module tb_cpu_mmu_csr_ctl;

    localparam int AW = 4;

    logic          sysclk;
    logic          sys_rst;
    logic [3:0]    IDB_3_0;
    logic          LCSR_n;
    logic          CUP;
    logic          CON;
    logic          CON_EFF;
    logic          BUSY;
    logic [AW-1:0] CADR;
    logic          CWE_n;
    logic          CDONE;

    int n_cmp;
    int n_fail;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_adr;
    logic          exp_cup;
    logic          exp_con;

    cpu_mmu_csr_ctl #(
        .ADDR_W (AW)
    ) dut (
        .sysclk  (sysclk),
        .sys_rst (sys_rst),
        .IDB_3_0 (IDB_3_0),
        .LCSR_n  (LCSR_n),
        .CUP     (CUP),
        .CON     (CON),
        .CON_EFF (CON_EFF),
        .BUSY    (BUSY),
        .CADR    (CADR),
        .CWE_n   (CWE_n),
        .CDONE   (CDONE)
    );

    // clock / reset
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // advance one rising edge and settle; inputs change and outputs are
    // sampled 1 time unit after the edge
    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_adr(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic cup, input logic con);
        check1({tag, "_cup"}, CUP, cup);
        check1({tag, "_con"}, CON, con);
        check1({tag, "_con_eff"}, CON_EFF, con);
        check1({tag, "_busy"}, BUSY, 1'b0);
        check_adr({tag, "_cadr"}, CADR, '0);
        check1({tag, "_cwe_n"}, CWE_n, 1'b1);
        check1({tag, "_cdone"}, CDONE, 1'b0);
    endtask

    // driver: one-cycle CSR write
    task automatic csr_write(input logic [3:0] val);
        LCSR_n  = 1'b0;
        IDB_3_0 = val;
        step();
        LCSR_n  = 1'b1;
        IDB_3_0 = 4'b0000;
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        sys_rst = 1'b1;
        LCSR_n  = 1'b1;
        IDB_3_0 = 4'b0000;

        // reset held for two cycles
        step();
        step();
        check_idle("reset", 1'b0, 1'b0);
        sys_rst = 1'b0;
        step();
        check_idle("post_reset", 1'b0, 1'b0);

        // plain load, no sequence
        csr_write(4'b0011);
        check_idle("plain_load", 1'b1, 1'b1);

        // full invalidate with CON written to 1 in the same strobe
        for (int i = 0; i < (1 << AW); i++) exp_q.push_back(AW'(i));
        csr_write(4'b0110);
        for (int i = 0; i < (1 << AW); i++) begin
            exp_adr = exp_q.pop_front();
            check1("inv_cwe_n", CWE_n, 1'b0);
            check_adr("inv_cadr", CADR, exp_adr);
            check1("inv_busy", BUSY, 1'b1);
            check1("inv_con", CON, 1'b1);
            check1("inv_con_eff", CON_EFF, 1'b0);
            check1("inv_cup", CUP, 1'b0);
            check1("inv_cdone", CDONE, 1'b0);
            step();
        end
        check1("inv_done_cdone", CDONE, 1'b1);
        check1("inv_done_busy", BUSY, 1'b0);
        check1("inv_done_cwe_n", CWE_n, 1'b1);
        check_adr("inv_done_cadr", CADR, '0);
        check1("inv_done_con_eff", CON_EFF, 1'b1);
        step();
        check_idle("inv_after", 1'b0, 1'b1);

        // write (with start bit set) during CLEAR at CADR=5: fields load,
        // sequence is not restarted, completion timing unchanged
        csr_write(4'b0110);
        exp_cup = 1'b0;
        exp_con = 1'b1;
        for (int i = 0; i < (1 << AW); i++) begin
            check_adr("wr_clr_cadr", CADR, AW'(i));
            check1("wr_clr_cwe_n", CWE_n, 1'b0);
            check1("wr_clr_busy", BUSY, 1'b1);
            check1("wr_clr_cup", CUP, exp_cup);
            check1("wr_clr_con", CON, exp_con);
            check1("wr_clr_con_eff", CON_EFF, 1'b0);
            if (i == 5) begin
                csr_write(4'b0101);
                exp_cup = 1'b1;
                exp_con = 1'b0;
            end else begin
                step();
            end
        end
        check1("wr_clr_cdone", CDONE, 1'b1);
        check1("wr_clr_done_busy", BUSY, 1'b0);
        step();
        check_idle("wr_clr_after", 1'b1, 1'b0);

        // reset in the middle of a sequence at CADR=9
        csr_write(4'b0110);
        for (int i = 0; i < 9; i++) step();
        check_adr("mid_rst_cadr9", CADR, 4'd9);
        check1("mid_rst_busy_before", BUSY, 1'b1);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        check_idle("mid_rst", 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step();
            check1("mid_rst_no_cdone", CDONE, 1'b0);
            check1("mid_rst_no_busy", BUSY, 1'b0);
        end

        // reserved bit alone: no field change, no sequence
        csr_write(4'b1000);
        check_idle("rsvd", 1'b0, 1'b0);
        step();
        check_idle("rsvd_next", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
